// File: rtl/rapcla_arbiter_if.sv
// Bus bundle between requesters, the shared RAPCLA adder and the response consumer.
// The arbiter takes the slave view; the environment (requesters, adder, consumer) takes master.
interface rapcla_arbiter_if #(
    parameter int SIZE      = 16,
    parameter int GROUPSIZE = 4,
    parameter int NREQ      = 4
);
    localparam int GROUPS = SIZE / GROUPSIZE;
    localparam int IDW    = $clog2(NREQ);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*SIZE-1:0]   req_a;
    logic [NREQ*SIZE-1:0]   req_b;
    logic [NREQ-1:0]        req_cin;
    logic [NREQ*GROUPS-1:0] req_rcon;
    logic [SIZE-1:0]        add_a;
    logic [SIZE-1:0]        add_b;
    logic                   add_cin;
    logic [GROUPS-1:0]      add_rcon;
    logic [SIZE-1:0]        add_sum;
    logic                   add_cout;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [SIZE-1:0]        rsp_sum;
    logic                   rsp_cout;
    logic [IDW-1:0]         rsp_id;
    logic                   rsp_approx;

    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_rcon, add_sum, add_cout, rsp_ready,
        output req_ready, add_a, add_b, add_cin, add_rcon,
               rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_approx
    );

    modport master (
        output req_valid, req_a, req_b, req_cin, req_rcon, add_sum, add_cout, rsp_ready,
        input  req_ready, add_a, add_b, add_cin, add_rcon,
               rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_approx
    );
endinterface

// File: rtl/rapcla_arbiter.sv
// Round-robin arbiter sharing one external RAPCLA adder between NREQ requesters,
// with a registered response slot and completed/approximate operation counters.
module rapcla_arbiter #(
    parameter int SIZE      = 16,
    parameter int GROUPSIZE = 4,
    parameter int NREQ      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    rapcla_arbiter_if.slave          bus,
    input  logic                     force_exact,
    output logic                     busy,
    output logic [15:0]              op_count,
    output logic [15:0]              approx_count
);
    localparam int GROUPS = SIZE / GROUPSIZE;
    localparam int IDW    = $clog2(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              state_r;
    logic [IDW-1:0]      last_grant_r;
    logic [IDW-1:0]      owner_r;
    logic [SIZE-1:0]     add_a_r;
    logic [SIZE-1:0]     add_b_r;
    logic                add_cin_r;
    logic [GROUPS-1:0]   add_rcon_r;
    logic                rsp_valid_r;
    logic [SIZE-1:0]     rsp_sum_r;
    logic                rsp_cout_r;
    logic [IDW-1:0]      rsp_id_r;
    logic                rsp_approx_r;
    logic                busy_r;
    logic [15:0]         op_count_r;
    logic [15:0]         approx_count_r;

    logic                grant_s;
    logic [IDW-1:0]      winner_s;
    logic [NREQ-1:0]     req_ready_s;

    // First valid requester searching upward from the one after the last winner.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        logic           found;
        int             idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Grant decision; held off while reset is asserted so req_ready reads 0 in reset.
    always_comb begin
        grant_s     = 1'b0;
        winner_s    = rr_pick(bus.req_valid, last_grant_r);
        req_ready_s = {NREQ{1'b0}};
        if (rst_n && (|bus.req_valid) &&
            ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && bus.rsp_ready))) begin
            grant_s     = 1'b1;
            req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            grant_s     = 1'b0;
            req_ready_s = {NREQ{1'b0}};
        end
    end

    // Control FSM: issue on grant, capture adder result in EXEC, hold response until popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            last_grant_r   <= IDW'(NREQ - 1);
            owner_r        <= {IDW{1'b0}};
            add_a_r        <= {SIZE{1'b0}};
            add_b_r        <= {SIZE{1'b0}};
            add_cin_r      <= 1'b0;
            add_rcon_r     <= {GROUPS{1'b0}};
            rsp_valid_r    <= 1'b0;
            rsp_sum_r      <= {SIZE{1'b0}};
            rsp_cout_r     <= 1'b0;
            rsp_id_r       <= {IDW{1'b0}};
            rsp_approx_r   <= 1'b0;
            busy_r         <= 1'b0;
            op_count_r     <= 16'd0;
            approx_count_r <= 16'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r <= ST_EXEC;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    rsp_sum_r    <= bus.add_sum;
                    rsp_cout_r   <= bus.add_cout;
                    rsp_id_r     <= owner_r;
                    rsp_approx_r <= |add_rcon_r;
                    rsp_valid_r  <= 1'b1;
                    state_r      <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r    <= 1'b0;
                        op_count_r     <= op_count_r + 16'd1;
                        approx_count_r <= approx_count_r + {15'd0, rsp_approx_r};
                        if (grant_s) begin
                            state_r <= ST_EXEC;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase

            // Operand load is shared by the IDLE grant and the HOLD pop-and-grant paths.
            if (grant_s) begin
                add_a_r      <= bus.req_a[winner_s*SIZE +: SIZE];
                add_b_r      <= bus.req_b[winner_s*SIZE +: SIZE];
                add_cin_r    <= bus.req_cin[winner_s];
                add_rcon_r   <= force_exact ? {GROUPS{1'b0}} : bus.req_rcon[winner_s*GROUPS +: GROUPS];
                last_grant_r <= winner_s;
                owner_r      <= winner_s;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.add_a      = add_a_r;
    assign bus.add_b      = add_b_r;
    assign bus.add_cin    = add_cin_r;
    assign bus.add_rcon   = add_rcon_r;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_sum    = rsp_sum_r;
    assign bus.rsp_cout   = rsp_cout_r;
    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_approx = rsp_approx_r;
    assign busy           = busy_r;
    assign op_count       = op_count_r;
    assign approx_count   = approx_count_r;
endmodule

// File: tb/tb_rapcla_arbiter.sv
// Scoreboard bench for rapcla_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_rapcla_arbiter;
    localparam int SIZE = 16;
    localparam int GS   = 4;
    localparam int NREQ = 4;

    logic        clk;
    logic        rst_n;
    logic        force_exact;
    logic        busy;
    logic [15:0] op_count;
    logic [15:0] approx_count;

    rapcla_arbiter_if #(.SIZE(SIZE), .GROUPSIZE(GS), .NREQ(NREQ)) bus ();

    rapcla_arbiter #(.SIZE(SIZE), .GROUPSIZE(GS), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .force_exact  (force_exact),
        .busy         (busy),
        .op_count     (op_count),
        .approx_count (approx_count)
    );

    // Exact adder standing in for the external RAPCLA.
    assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {16'd0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [15:0] TA [4] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h0F0F};
    localparam logic [15:0] TB [4] = '{16'h1111, 16'h8000, 16'h0000, 16'h00F0};
    localparam logic        TI [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    localparam logic [3:0]  TR [4] = '{4'h0, 4'h2, 4'h0, 4'h8};
    localparam logic [15:0] TS [4] = '{16'h2345, 16'h0000, 16'h0000, 16'h1000};
    localparam logic        TC [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic        TX [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic [1:0]  id;
        logic        approx;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] s, input logic c, input logic [1:0] id, input logic x);
        exp_t e;
        e.sum = s; e.cout = c; e.id = id; e.approx = x;
        sb.push_back(e);
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic cin, input logic [3:0] rcon);
        bus.req_a[i*SIZE +: SIZE] = a;
        bus.req_b[i*SIZE +: SIZE] = b;
        bus.req_cin[i]            = cin;
        bus.req_rcon[i*GS +: GS]  = rcon;
    endtask

    task automatic load_table();
        for (int i = 0; i < NREQ; i++) set_req(i, TA[i], TB[i], TI[i], TR[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Monitor: compare the head of the scoreboard on every response handshake.
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_sum",    {16'd0, bus.rsp_sum},   {16'd0, e.sum});
                chk("rsp_cout",   {31'd0, bus.rsp_cout},  {31'd0, e.cout});
                chk("rsp_id",     {30'd0, bus.rsp_id},    {30'd0, e.id});
                chk("rsp_approx", {31'd0, bus.rsp_approx},{31'd0, e.approx});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        force_exact = 1'b0;
        bus.req_valid = 4'b0000;
        bus.req_a = '0; bus.req_b = '0; bus.req_cin = '0; bus.req_rcon = '0;
        bus.rsp_ready = 1'b0;
        #1;
        chk("rst_req_ready", {28'd0, bus.req_ready}, 32'd0);
        chk("rst_add_a",     {16'd0, bus.add_a},     32'd0);
        chk("rst_add_rcon",  {28'd0, bus.add_rcon},  32'd0);
        chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_sum",   {16'd0, bus.rsp_sum},   32'd0);
        chk("rst_busy",      {31'd0, busy},          32'd0);
        chk("rst_op_count",  {16'd0, op_count},      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2.
        set_req(2, 16'h00FF, 16'h0001, 1'b0, 4'h0);
        bus.req_valid = 4'b0100;
        bus.rsp_ready = 1'b1;
        #1;
        chk("t1_grant", {28'd0, bus.req_ready}, 32'h4);
        push(16'h0100, 1'b0, 2'd2, 1'b0);
        tick();
        bus.req_valid = 4'b0000;
        #1;
        chk("t1_ready_exec", {28'd0, bus.req_ready}, 32'd0);
        chk("t1_add_a",      {16'd0, bus.add_a},     32'h00FF);
        chk("t1_busy",       {31'd0, busy},          32'd1);
        tick();
        chk("t1_rsp_valid",  {31'd0, bus.rsp_valid}, 32'd1);
        tick();
        chk("t1_op_count",   {16'd0, op_count},      32'd1);
        chk("t1_idle",       {31'd0, busy},          32'd0);

        // Round-robin from reset with all four requesters pending.
        do_reset();
        load_table();
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1;
            chk("rr_grant", {28'd0, bus.req_ready}, 32'd1 << (g % 4));
            push(TS[g % 4], TC[g % 4], 2'(g % 4), TX[g % 4]);
            tick();
            if (g == 4) bus.req_valid = 4'b0000;
            #1;
            chk("rr_gap", {28'd0, bus.req_ready}, 32'd0);
            tick();
        end
        tick();
        chk("rr_op_count",     {16'd0, op_count},     32'd5);
        chk("rr_approx_count", {16'd0, approx_count}, 32'd2);

        // Backpressure: response held while requesters wait.
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        chk("bp_grant1", {28'd0, bus.req_ready}, 32'h2);
        push(TS[1], TC[1], 2'd1, TX[1]);
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("bp_no_grant", {28'd0, bus.req_ready}, 32'd0);
            chk("bp_valid",    {31'd0, bus.rsp_valid}, 32'd1);
            chk("bp_sum",      {16'd0, bus.rsp_sum},   {16'd0, TS[1]});
            chk("bp_id",       {30'd0, bus.rsp_id},    32'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_pop_grant", {28'd0, bus.req_ready}, 32'h4);
        push(TS[2], TC[2], 2'd2, TX[2]);
        tick();
        bus.req_valid = 4'b0000;
        chk("bp_popped", {31'd0, bus.rsp_valid}, 32'd0);
        tick();
        tick();
        chk("bp_op_count",     {16'd0, op_count},     32'd7);
        chk("bp_approx_count", {16'd0, approx_count}, 32'd3);

        // Approximation mask, then same operands forced exact.
        do_reset();
        set_req(0, 16'hFFFF, 16'h0001, 1'b0, 4'hF);
        bus.req_valid = 4'b0001;
        #1;
        chk("ap_grant", {28'd0, bus.req_ready}, 32'h1);
        push(16'h0000, 1'b1, 2'd0, 1'b1);
        tick();
        bus.req_valid = 4'b0000;
        chk("ap_rcon", {28'd0, bus.add_rcon}, 32'hF);
        tick();
        tick();
        force_exact = 1'b1;
        bus.req_valid = 4'b0001;
        #1;
        chk("fe_grant", {28'd0, bus.req_ready}, 32'h1);
        push(16'h0000, 1'b1, 2'd0, 1'b0);
        tick();
        force_exact = 1'b0;
        bus.req_valid = 4'b0000;
        chk("fe_rcon", {28'd0, bus.add_rcon}, 32'h0);
        tick();
        tick();
        chk("ap_op_count",     {16'd0, op_count},     32'd2);
        chk("ap_approx_count", {16'd0, approx_count}, 32'd1);

        // Reset during EXEC discards the in-flight op.
        load_table();
        bus.req_valid = 4'b1000;
        #1;
        chk("mr_grant", {28'd0, bus.req_ready}, 32'h8);
        tick();
        chk("mr_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_req_ready", {28'd0, bus.req_ready}, 32'd0);
        chk("mr_add_a",     {16'd0, bus.add_a},     32'd0);
        chk("mr_add_cin",   {31'd0, bus.add_cin},   32'd0);
        chk("mr_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        chk("mr_rsp_id",    {30'd0, bus.rsp_id},    32'd0);
        chk("mr_busy_rst",  {31'd0, busy},          32'd0);
        chk("mr_op_count",  {16'd0, op_count},      32'd0);
        chk("mr_apx_count", {16'd0, approx_count},  32'd0);
        tick();
        bus.req_valid = 4'b1111;
        rst_n = 1'b1;
        #1;
        chk("mr_first_grant", {28'd0, bus.req_ready}, 32'h1);
        push(TS[0], TC[0], 2'd0, TX[0]);
        tick();
        bus.req_valid = 4'b0000;
        tick();
        tick();
        chk("mr_op_after",  {16'd0, op_count}, 32'd1);
        chk("sb_empty",     sb.size(),         32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rapcla_arbiter.md
# rapcla_arbiter

Shares one external reconfigurable approximate carry-lookahead adder (RAPCLA) between NREQ requesters. Round-robin arbitration selects a requester and registers its operands and per-group approximation mask onto the adder inputs. One cycle later it captures the sum and carry-out into a response register with a valid/ready handshake. It also keeps running counters of completed and approximate operations for quality monitoring.

## Interface
- SIZE, 16, adder width in bits; a multiple of GROUPSIZE
- GROUPSIZE, 4, RAPCLA group size; GROUPS = SIZE/GROUPSIZE
- NREQ, 4, number of requesters, 2..8; IDW = clog2(NREQ)
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- REQ_VALID  in  NREQ  per-requester request valid
- REQ_READY  out  NREQ  one-hot grant, combinational
- REQ_A, REQ_B  in  NREQ*SIZE  operands; requester i occupies slice [i*SIZE +: SIZE]
- REQ_CIN  in  NREQ  carry-in per requester
- REQ_RCON  in  NREQ*GROUPS  approximation mask per requester; bit g=1 means group g+1 uses the approximate carry
- FORCE_EXACT  in  1  forces the issued mask to all-zero
- ADD_A, ADD_B  out  SIZE  registered adder operands
- ADD_CIN  out  1  registered adder carry-in
- ADD_RCON  out  GROUPS  registered ApproxRCON; bit g drives ApproxRCON[g+1]
- ADD_SUM  in  SIZE  adder sum
- ADD_COUT  in  1  adder carry-out
- RSP_VALID  out  1  response valid
- RSP_READY  in  1  response consumer ready
- RSP_SUM  out  SIZE  captured sum
- RSP_COUT  out  1  captured carry-out
- RSP_ID  out  IDW  index of the requester that owns the response
- RSP_APPROX  out  1  at least one group was approximate for this op
- BUSY  out  1  state is not IDLE
- OP_COUNT  out  16  completed responses; wraps
- APPROX_COUNT  out  16  completed responses with RSP_APPROX=1; wraps

## Operation
- FSM has three states: IDLE, EXEC, HOLD.
- IDLE: grant when any REQ_VALID is high; next state EXEC.
- EXEC: ADD_* outputs are stable and the adder settles. At the next edge, capture ADD_SUM, ADD_COUT, the owner ID and the approx flag into RSP_*. Set RSP_VALID. Next state HOLD.
- HOLD: RSP_VALID=1 and RSP_* are held stable.
  - RSP_READY=1 with a pending request: pop the response and grant in the same cycle; next state EXEC.
  - RSP_READY=1 with no pending request: next state IDLE.
  - RSP_READY=0: stay in HOLD and make no grant.
- Grant condition: (state==IDLE, or state==HOLD with RSP_READY=1) and |REQ_VALID.
- REQ_READY is one-hot to the winner and 0 in all other cases. Acceptance is REQ_VALID[i] & REQ_READY[i] at the edge.
- Round-robin: search starts at last_grant+1 modulo NREQ. After reset last_grant=NREQ-1, so requester 0 has top priority first.
- On a grant: ADD_A, ADD_B and ADD_CIN load from the winner's slice. ADD_RCON loads the winner's REQ_RCON, or 0 if FORCE_EXACT=1 at that edge.
- The approx flag is |ADD_RCON and is captured with the result.
- ADD_* outputs keep their last values outside EXEC; they are not cleared.
- OP_COUNT increments on each RSP_VALID & RSP_READY edge.
- APPROX_COUNT increments on the same edge when RSP_APPROX=1.
- Both counters wrap 0xFFFF to 0.

## Timing
- Reset values: state IDLE; REQ_READY 0; all ADD_* 0; RSP_VALID 0; RSP_SUM, RSP_COUT, RSP_ID, RSP_APPROX 0; BUSY 0; counters 0; last_grant NREQ-1.
- Latency: a request accepted at edge k gives RSP_VALID=1 after edge k+1.
- Throughput: with RSP_READY held at 1, one operation every 2 cycles.
- The adder path has one full cycle from register to ADD_SUM; it is not pipelined.
- Simultaneous response pop and new grant in HOLD is legal. RSP_* update at the following edge.
- REQ_VALID dropped before it is granted: no grant and no effect.
- Asynchronous reset in EXEC or HOLD discards the in-flight operation. No response is produced, and the counters are not incremented.
- FORCE_EXACT is sampled only at the grant edge. Changing it in EXEC or HOLD does not alter the in-flight op.

## Test plan
- Single request: requester 2 sends A=0x00FF, B=0x0001, CIN=0, RCON=0. Expect REQ_READY=0b0100 for one cycle, then RSP_VALID after edge k+1 with RSP_SUM=0x0100, RSP_COUT=0, RSP_ID=2, RSP_APPROX=0, OP_COUNT=1.
- Round-robin: all four requesters held valid with RSP_READY=1. Expect grant order 0,1,2,3,0 with one grant every 2 cycles.
- Backpressure: hold RSP_READY=0 for 5 cycles with requesters pending. Expect no REQ_READY pulses and RSP_* stable. When RSP_READY rises, expect a pop and the next grant in the same cycle.
- Approximation: send A=0xFFFF, B=0x0001, RCON=0b1111, then the same operands with FORCE_EXACT=1. Expect RSP_APPROX 1 then 0, ADD_RCON 0xF then 0x0, and APPROX_COUNT=1 with OP_COUNT=2.
- Reset mid-op: assert RST_N=0 during EXEC. Expect every output at its reset value immediately, RSP_VALID never asserts, and after release requester 0 wins first.
